// File: rtl/rom_stream_router.sv
// Routes a size-headed ROM download stream into 16-bit SDRAM word writes followed by
// byte writes into N_BRAM BRAM regions, with source backpressure and overflow detection.
module rom_stream_router #(
  parameter int unsigned       N_BRAM   = 6,
  parameter int unsigned       SDR_AW   = 25,
  parameter int unsigned       BRAM_AW  = 20,
  parameter logic [SDR_AW-1:0] SDR_BASE = '0
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               download,
  input  logic               ioctl_wr,
  input  logic [7:0]         ioctl_data,
  output logic               ioctl_wait,
  output logic [SDR_AW-1:0]  sdr_addr,
  output logic [15:0]        sdr_data,
  output logic [1:0]         sdr_be,
  output logic               sdr_req,
  input  logic               sdr_rdy,
  output logic [BRAM_AW-1:0] bram_addr,
  output logic [7:0]         bram_data,
  output logic [N_BRAM-1:0]  bram_cs,
  output logic               bram_wr,
  output logic               done,
  output logic               overflow
);

  localparam int unsigned RW = $clog2(N_BRAM + 2);
  localparam int unsigned HB = 2 * (N_BRAM + 1);

  typedef enum logic [2:0] {StIdle, StHdr, StSdr, StSdrWait, StBram, StFlush, StDone} state_e;

  state_e              r_state, w_state;
  logic [15:0]         r_size [N_BRAM+1];
  logic [15:0]         w_size [N_BRAM+1];
  logic [4:0]          r_hcnt, w_hcnt;
  logic                r_hdr_full, w_hdr_full;
  logic [RW-1:0]       r_reg, w_reg;
  logic [23:0]         r_cnt, w_cnt;
  logic                r_last, w_last;
  logic [7:0]          r_lo, w_lo;
  logic                r_half, w_half;
  logic [SDR_AW-1:0]   r_sdr_addr, w_sdr_addr;
  logic [15:0]         r_sdr_data, w_sdr_data;
  logic [1:0]          r_sdr_be, w_sdr_be;
  logic                r_sdr_req, w_sdr_req;
  logic [BRAM_AW-1:0]  r_bram_addr, w_bram_addr;
  logic [7:0]          r_bram_data, w_bram_data;
  logic [N_BRAM-1:0]   r_bram_cs, w_bram_cs;
  logic                r_bram_wr, w_bram_wr;
  logic                r_done, w_done;
  logic                r_overflow, w_overflow;

  logic                w_wait, w_accept, w_hit;
  logic [RW-1:0]       w_first, w_next;
  logic [23:0]         w_end, w_cnt_inc;
  logic [N_BRAM-1:0]   w_cs;

  // Region lookup: first nonzero region overall, next nonzero BRAM region after the current one.
  always_comb begin
    w_first = RW'(N_BRAM + 1);
    w_next  = RW'(N_BRAM + 1);
    w_end   = '0;
    for (int k = int'(N_BRAM); k >= 0; k--) begin
      if (r_size[k] != 16'd0) w_first = RW'(k);
      if (k >= 1 && r_size[k] != 16'd0 && RW'(k) > r_reg) w_next = RW'(k);
      if (r_reg == RW'(k)) w_end = {r_size[k], 8'h00};
    end
    for (int k = 0; k < int'(N_BRAM); k++) w_cs[k] = (r_reg == RW'(k + 1));
  end

  assign w_wait    = r_sdr_req | ((r_state == StHdr) & r_hdr_full);
  assign w_accept  = ioctl_wr & ~w_wait;
  assign w_cnt_inc = r_cnt + 24'd1;
  assign w_hit     = (w_cnt_inc == w_end);

  always_comb begin
    w_state     = r_state;
    w_size      = r_size;
    w_hcnt      = r_hcnt;
    w_hdr_full  = r_hdr_full;
    w_reg       = r_reg;
    w_cnt       = r_cnt;
    w_last      = r_last;
    w_lo        = r_lo;
    w_half      = r_half;
    w_sdr_addr  = r_sdr_addr;
    w_sdr_data  = r_sdr_data;
    w_sdr_be    = r_sdr_be;
    w_sdr_req   = r_sdr_req;
    w_bram_addr = r_bram_addr;
    w_bram_data = r_bram_data;
    w_bram_cs   = r_bram_cs;
    w_bram_wr   = 1'b0;
    w_done      = r_done;
    w_overflow  = r_overflow;

    unique case (r_state)
      StIdle: begin
        if (download) begin
          w_state    = StHdr;
          w_done     = 1'b0;
          w_overflow = 1'b0;
          w_hcnt     = '0;
          w_hdr_full = 1'b0;
          w_sdr_addr = SDR_BASE;
          w_half     = 1'b0;
          w_last     = 1'b0;
          w_cnt      = '0;
        end
      end
      StHdr: begin
        if (!download) begin
          w_state = StIdle;
        end else if (r_hdr_full) begin
          // Transition cycle: sizes are complete, pick the first populated region.
          w_hdr_full = 1'b0;
          w_reg      = w_first;
          w_cnt      = '0;
          if (w_first == '0)                 w_state = StSdr;
          else if (w_first <= RW'(N_BRAM))   w_state = StBram;
          else                               w_state = StDone;
        end else if (w_accept) begin
          for (int k = 0; k <= int'(N_BRAM); k++) begin
            if (int'(r_hcnt[4:1]) == k) begin
              if (!r_hcnt[0]) w_size[k][15:8] = ioctl_data;
              else            w_size[k][7:0]  = ioctl_data;
            end
          end
          if (r_hcnt == 5'(HB - 1)) w_hdr_full = 1'b1;
          else                      w_hcnt     = r_hcnt + 5'd1;
        end
      end
      StSdr: begin
        if (!download) begin
          if (r_half) begin
            w_state    = StFlush;
            w_sdr_data = {8'h00, r_lo};
            w_sdr_be   = 2'b01;
            w_sdr_req  = 1'b1;
            w_half     = 1'b0;
          end else begin
            w_state = StIdle;
          end
        end else if (w_accept) begin
          w_cnt  = w_hit ? 24'd0 : w_cnt_inc;
          w_last = w_hit;
          if (!r_half) begin
            w_lo   = ioctl_data;
            w_half = 1'b1;
          end else begin
            w_half     = 1'b0;
            w_sdr_data = {ioctl_data, r_lo};
            w_sdr_be   = 2'b11;
            w_sdr_req  = 1'b1;
            w_state    = StSdrWait;
          end
        end
      end
      StSdrWait: begin
        if (sdr_rdy) begin
          w_sdr_req  = 1'b0;
          w_sdr_addr = r_sdr_addr + SDR_AW'(2);
          if (!download) begin
            w_state = StIdle;
          end else if (r_last) begin
            w_last  = 1'b0;
            w_reg   = w_next;
            w_state = (w_next <= RW'(N_BRAM)) ? StBram : StDone;
          end else begin
            w_state = StSdr;
          end
        end
      end
      StBram: begin
        if (!download) begin
          w_state = StIdle;
        end else if (w_accept) begin
          w_bram_wr   = 1'b1;
          w_bram_data = ioctl_data;
          w_bram_addr = BRAM_AW'(r_cnt);
          w_bram_cs   = w_cs;
          w_cnt       = w_hit ? 24'd0 : w_cnt_inc;
          if (w_hit) begin
            w_reg   = w_next;
            w_state = (w_next <= RW'(N_BRAM)) ? StBram : StDone;
          end
        end
      end
      StFlush: begin
        if (sdr_rdy) begin
          w_sdr_req  = 1'b0;
          w_sdr_addr = r_sdr_addr + SDR_AW'(2);
          w_state    = StIdle;
        end
      end
      StDone: begin
        if (!download)     w_state    = StIdle;
        else if (w_accept) w_overflow = 1'b1;
      end
      default: w_state = StIdle;
    endcase

    if (w_state == StDone) w_done = 1'b1;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state     <= StIdle;
      r_size      <= '{default: '0};
      r_hcnt      <= '0;
      r_hdr_full  <= 1'b0;
      r_reg       <= '0;
      r_cnt       <= '0;
      r_last      <= 1'b0;
      r_lo        <= '0;
      r_half      <= 1'b0;
      r_sdr_addr  <= '0;
      r_sdr_data  <= '0;
      r_sdr_be    <= '0;
      r_sdr_req   <= 1'b0;
      r_bram_addr <= '0;
      r_bram_data <= '0;
      r_bram_cs   <= '0;
      r_bram_wr   <= 1'b0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_size      <= w_size;
      r_hcnt      <= w_hcnt;
      r_hdr_full  <= w_hdr_full;
      r_reg       <= w_reg;
      r_cnt       <= w_cnt;
      r_last      <= w_last;
      r_lo        <= w_lo;
      r_half      <= w_half;
      r_sdr_addr  <= w_sdr_addr;
      r_sdr_data  <= w_sdr_data;
      r_sdr_be    <= w_sdr_be;
      r_sdr_req   <= w_sdr_req;
      r_bram_addr <= w_bram_addr;
      r_bram_data <= w_bram_data;
      r_bram_cs   <= w_bram_cs;
      r_bram_wr   <= w_bram_wr;
      r_done      <= w_done;
      r_overflow  <= w_overflow;
    end
  end

  assign ioctl_wait = w_wait;
  assign sdr_addr   = r_sdr_addr;
  assign sdr_data   = r_sdr_data;
  assign sdr_be     = r_sdr_be;
  assign sdr_req    = r_sdr_req;
  assign bram_addr  = r_bram_addr;
  assign bram_data  = r_bram_data;
  assign bram_cs    = r_bram_cs;
  assign bram_wr    = r_bram_wr;
  assign done       = r_done;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_rom_stream_router.sv
// Bench for rom_stream_router (N_BRAM=2): table of download scenarios checked against a
// byte-pattern model, plus hand sequences for flush, first-BRAM-byte timing and reset.
module tb_rom_stream_router;

  localparam int unsigned       N_BRAM  = 2;
  localparam int unsigned       SDR_AW  = 25;
  localparam int unsigned       BRAM_AW = 20;
  localparam logic [SDR_AW-1:0] BASE    = 25'h100;

  logic               CLK = 1'b0;
  logic               RSTn = 1'b0;
  logic               download = 1'b0;
  logic               ioctl_wr = 1'b0;
  logic [7:0]         ioctl_data = 8'h00;
  logic               ioctl_wait;
  logic [SDR_AW-1:0]  sdr_addr;
  logic [15:0]        sdr_data;
  logic [1:0]         sdr_be;
  logic               sdr_req;
  logic               sdr_rdy = 1'b0;
  logic [BRAM_AW-1:0] bram_addr;
  logic [7:0]         bram_data;
  logic [N_BRAM-1:0]  bram_cs;
  logic               bram_wr;
  logic               done;
  logic               overflow;

  rom_stream_router #(
    .N_BRAM   (N_BRAM),
    .SDR_AW   (SDR_AW),
    .BRAM_AW  (BRAM_AW),
    .SDR_BASE (BASE)
  ) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .download   (download),
    .ioctl_wr   (ioctl_wr),
    .ioctl_data (ioctl_data),
    .ioctl_wait (ioctl_wait),
    .sdr_addr   (sdr_addr),
    .sdr_data   (sdr_data),
    .sdr_be     (sdr_be),
    .sdr_req    (sdr_req),
    .sdr_rdy    (sdr_rdy),
    .bram_addr  (bram_addr),
    .bram_data  (bram_data),
    .bram_cs    (bram_cs),
    .bram_wr    (bram_wr),
    .done       (done),
    .overflow   (overflow)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] sz0, sz1, sz2;
    int          dly, nbytes, exp_sdr, exp_b0, exp_b1;
    logic        exp_done, exp_ovf;
  } vec_t;

  vec_t  tbl [7];
  int    checks = 0;
  int    errors = 0;
  int    rdy_delay = 0;
  int    rdy_cnt = 0;
  bit    pattern = 1'b1;

  // Monitor state (written only by the monitor process).
  int                n_sdr, n_b0, n_b1, mon_bad, log_n;
  bit                dl_prev = 1'b0;
  string             bad_msg = "none";
  logic [SDR_AW-1:0] log_addr [256];
  logic [15:0]       log_data [256];
  logic [1:0]        log_be   [256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    while (ioctl_wait && t < 1000) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 1000) chk("wait_timeout", 32'(t), 32'd0);
    ioctl_data = b;
    ioctl_wr   = 1'b1;
    @(negedge CLK);
    ioctl_wr   = 1'b0;
  endtask

  task automatic send_hdr(input logic [15:0] s0, input logic [15:0] s1, input logic [15:0] s2);
    send_byte(s0[15:8]); send_byte(s0[7:0]);
    send_byte(s1[15:8]); send_byte(s1[7:0]);
    send_byte(s2[15:8]); send_byte(s2[7:0]);
  endtask

  task automatic run_scn(input int k);
    vec_t v;
    v = tbl[k];
    rdy_delay = v.dly;
    pattern   = 1'b1;
    download  = 1'b1;
    @(negedge CLK);
    chk($sformatf("s%0d start_done", k), 32'(done), 32'd0);
    chk($sformatf("s%0d start_ovf", k), 32'(overflow), 32'd0);
    send_hdr(v.sz0, v.sz1, v.sz2);
    for (int p = 0; p < v.nbytes; p++) send_byte(8'(p));
    repeat (30) @(negedge CLK);
    #2;
    chk($sformatf("s%0d sdr_writes", k), 32'(n_sdr), 32'(v.exp_sdr));
    chk($sformatf("s%0d bram0_writes", k), 32'(n_b0), 32'(v.exp_b0));
    chk($sformatf("s%0d bram1_writes", k), 32'(n_b1), 32'(v.exp_b1));
    chk($sformatf("s%0d done", k), 32'(done), 32'(v.exp_done));
    chk($sformatf("s%0d overflow", k), 32'(overflow), 32'(v.exp_ovf));
    chk($sformatf("s%0d monitor(%s)", k, bad_msg), 32'(mon_bad), 32'd0);
    download = 1'b0;
    repeat (3) @(negedge CLK);
  endtask

  // SDRAM controller model: one-cycle rdy after rdy_delay cycles of a pending request.
  initial begin
    forever begin
      @(negedge CLK);
      sdr_rdy = 1'b0;
      if (!sdr_req) rdy_cnt = 0;
      else if (rdy_cnt >= rdy_delay) begin
        sdr_rdy = 1'b1;
        rdy_cnt = 0;
      end else rdy_cnt++;
    end
  end

  // Monitor: logs SDRAM writes and checks data/addresses against the 0..255 byte pattern.
  initial begin
    forever begin
      @(negedge CLK);
      #1;
      if (!RSTn || (download && !dl_prev)) begin
        n_sdr = 0; n_b0 = 0; n_b1 = 0; mon_bad = 0; log_n = 0;
      end
      dl_prev = download;
      if (sdr_req && !ioctl_wait) begin
        mon_bad++;
        bad_msg = "ioctl_wait low during request";
      end
      if (sdr_req && sdr_rdy) begin
        if (log_n < 256) begin
          log_addr[log_n] = sdr_addr;
          log_data[log_n] = sdr_data;
          log_be[log_n]   = sdr_be;
          log_n++;
        end
        if (pattern && (sdr_addr !== BASE + SDR_AW'(2 * n_sdr) || sdr_be !== 2'b11 ||
                        sdr_data !== {8'(2 * n_sdr + 1), 8'(2 * n_sdr)})) begin
          mon_bad++;
          bad_msg = $sformatf("sdr word %0d addr=%0h data=%0h be=%0b", n_sdr, sdr_addr,
                              sdr_data, sdr_be);
        end
        n_sdr++;
      end
      if (bram_wr) begin
        if (bram_cs == 2'b01 && n_b1 == 0) begin
          if (bram_addr !== BRAM_AW'(n_b0) || bram_data !== 8'(n_b0)) begin
            mon_bad++;
            bad_msg = $sformatf("bram0 #%0d addr=%0h data=%0h", n_b0, bram_addr, bram_data);
          end
          n_b0++;
        end else if (bram_cs == 2'b10) begin
          if (bram_addr !== BRAM_AW'(n_b1) || bram_data !== 8'(n_b1)) begin
            mon_bad++;
            bad_msg = $sformatf("bram1 #%0d addr=%0h data=%0h", n_b1, bram_addr, bram_data);
          end
          n_b1++;
        end else begin
          mon_bad++;
          bad_msg = $sformatf("bram_wr with cs=%0b after %0d region-1 writes", bram_cs, n_b1);
        end
      end
    end
  end

  initial begin
    //          sz0    sz1    sz2   dly nbytes sdr  b0   b1  done  ovf
    tbl[0] = '{16'd1, 16'd1, 16'd1, 0, 768, 128, 256, 256, 1'b1, 1'b0};
    tbl[1] = '{16'd1, 16'd1, 16'd1, 7, 768, 128, 256, 256, 1'b1, 1'b0};
    tbl[2] = '{16'd0, 16'd1, 16'd1, 0, 512,   0, 256, 256, 1'b1, 1'b0};
    tbl[3] = '{16'd0, 16'd1, 16'd0, 0, 257,   0, 256,   0, 1'b1, 1'b1};
    tbl[4] = '{16'd1, 16'd0, 16'd1, 3, 512, 128,   0, 256, 1'b1, 1'b0};
    tbl[5] = '{16'd0, 16'd0, 16'd0, 0,   0,   0,   0,   0, 1'b1, 1'b0};
    tbl[6] = '{16'd1, 16'd1, 16'd1, 0, 300, 128,  44,   0, 1'b0, 1'b0};

    repeat (2) @(negedge CLK);
    chk("reset sdr_req", 32'(sdr_req), 32'd0);
    chk("reset ioctl_wait", 32'(ioctl_wait), 32'd0);
    chk("reset sdr_addr", 32'(sdr_addr), 32'd0);
    chk("reset bram_cs", 32'(bram_cs), 32'd0);
    chk("reset bram_wr", 32'(bram_wr), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    RSTn = 1'b1;
    @(negedge CLK);

    for (int k = 0; k < 7; k++) run_scn(k);

    // First BRAM byte lands one cycle after its strobe at offset 0 of region 1.
    rdy_delay = 0;
    download  = 1'b1;
    @(negedge CLK);
    send_hdr(16'd0, 16'd1, 16'd1);
    send_byte(8'h00);
    chk("first_bram wr", 32'(bram_wr), 32'd1);
    chk("first_bram cs", 32'(bram_cs), 32'd1);
    chk("first_bram addr", 32'(bram_addr), 32'd0);
    chk("first_bram req", 32'(sdr_req), 32'd0);
    download = 1'b0;
    repeat (3) @(negedge CLK);

    // Download ends with a half word latched: flushed with low byte enable only.
    pattern  = 1'b0;
    download = 1'b1;
    @(negedge CLK);
    send_hdr(16'd1, 16'd1, 16'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    download = 1'b0;
    repeat (20) @(negedge CLK);
    #2;
    chk("flush count", 32'(log_n), 32'd2);
    chk("flush w0 addr", 32'(log_addr[0]), 32'(BASE));
    chk("flush w0 data", 32'(log_data[0]), 32'h0000BBAA);
    chk("flush w0 be", 32'(log_be[0]), 32'd3);
    chk("flush w1 addr", 32'(log_addr[1]), 32'(BASE) + 32'd2);
    chk("flush w1 data", 32'(log_data[1]), 32'h000000CC);
    chk("flush w1 be", 32'(log_be[1]), 32'd1);
    chk("flush idle req", 32'(sdr_req), 32'd0);
    repeat (3) @(negedge CLK);

    // Reset during a pending SDRAM request, then restart with download still high.
    rdy_delay = 50;
    pattern   = 1'b1;
    download  = 1'b1;
    @(negedge CLK);
    send_hdr(16'd1, 16'd1, 16'd1);
    send_byte(8'h00);
    send_byte(8'h01);
    repeat (2) @(negedge CLK);
    chk("rst_pre sdr_req", 32'(sdr_req), 32'd1);
    RSTn = 1'b0;
    #1;
    chk("rst sdr_req", 32'(sdr_req), 32'd0);
    chk("rst ioctl_wait", 32'(ioctl_wait), 32'd0);
    chk("rst sdr_addr", 32'(sdr_addr), 32'd0);
    chk("rst sdr_data", 32'(sdr_data), 32'd0);
    chk("rst sdr_be", 32'(sdr_be), 32'd0);
    @(negedge CLK);
    RSTn = 1'b1;
    run_scn(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
